// File: rtl/leg_dec_pkg.sv
// Shared LEGv8 decode definitions: opcode patterns, ALU op codes, control-bit
// positions and the combinational instruction decoder used by decode_stage_q.
package leg_dec_pkg;

    localparam int DEC_IMM_W = 64;

    localparam logic [5:0]  OP_B     = 6'b000101;
    localparam logic [5:0]  OP_BL    = 6'b100101;
    localparam logic [7:0]  OP_CBZ   = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ  = 8'b10110101;
    localparam logic [10:0] OP_LDUR  = 11'b11111000010;
    localparam logic [10:0] OP_STUR  = 11'b11111000000;
    localparam logic [10:0] OP_ADD   = 11'b10001011000;
    localparam logic [10:0] OP_SUB   = 11'b11001011000;
    localparam logic [10:0] OP_AND   = 11'b10001010000;
    localparam logic [10:0] OP_ORR   = 11'b10101010000;
    localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI  = 10'b1101000100;
    localparam logic [8:0]  OP_MOVK  = 9'b111100101;

    localparam logic [1:0]  ALU_OP_MEM   = 2'b00;
    localparam logic [1:0]  ALU_OP_CB    = 2'b01;
    localparam logic [1:0]  ALU_OP_ARITH = 2'b10;

    localparam int CTRL_W        = 9;
    localparam int CTRL_REG2LOC  = 8;
    localparam int CTRL_UNCOND   = 7;
    localparam int CTRL_BRANCH   = 6;
    localparam int CTRL_MEMREAD  = 5;
    localparam int CTRL_MEMTOREG = 4;
    localparam int CTRL_MEMWRITE = 3;
    localparam int CTRL_ALUSRC   = 2;
    localparam int CTRL_REGWRITE = 1;
    localparam int CTRL_ILLEGAL  = 0;

    typedef struct packed {
        logic [4:0]           rs1;
        logic [4:0]           rs2;
        logic [4:0]           rd;
        logic [DEC_IMM_W-1:0] imm;
        logic [CTRL_W-1:0]    ctrl;
        logic [1:0]           alu_op;
    } dec_pkt_t;

    // imm is produced at 64 bits; callers with a narrower datapath truncate it.
    function automatic dec_pkt_t decode(input logic [31:0] inst);
        dec_pkt_t             p;
        logic [DEC_IMM_W-1:0] hw;
        // NOTE: every field gets a default first so no path leaves anything unassigned.
        p  = '0;
        hw = {48'b0, inst[20:5]};
        if (inst[31:26] == OP_B || inst[31:26] == OP_BL) begin
            p.ctrl[CTRL_UNCOND] = 1'b1;
            p.imm               = {{38{inst[25]}}, inst[25:0]};
        end else if (inst[31:24] == OP_CBZ || inst[31:24] == OP_CBNZ) begin
            p.ctrl[CTRL_REG2LOC] = 1'b1;
            p.ctrl[CTRL_BRANCH]  = 1'b1;
            p.alu_op             = ALU_OP_CB;
            p.rs2                = inst[4:0];
            p.imm                = {{45{inst[23]}}, inst[23:5]};
        end else if (inst[31:21] == OP_LDUR) begin
            p.ctrl[CTRL_MEMREAD]  = 1'b1;
            p.ctrl[CTRL_MEMTOREG] = 1'b1;
            p.ctrl[CTRL_ALUSRC]   = 1'b1;
            p.ctrl[CTRL_REGWRITE] = 1'b1;
            p.rs1                 = inst[9:5];
            p.rd                  = inst[4:0];
            p.imm                 = {{55{inst[20]}}, inst[20:12]};
        end else if (inst[31:21] == OP_STUR) begin
            p.ctrl[CTRL_REG2LOC]  = 1'b1;
            p.ctrl[CTRL_MEMWRITE] = 1'b1;
            p.ctrl[CTRL_ALUSRC]   = 1'b1;
            p.rs1                 = inst[9:5];
            p.rs2                 = inst[4:0];
            p.imm                 = {{55{inst[20]}}, inst[20:12]};
        end else if (inst[31:21] == OP_ADD || inst[31:21] == OP_SUB ||
                     inst[31:21] == OP_AND || inst[31:21] == OP_ORR) begin
            p.ctrl[CTRL_REGWRITE] = 1'b1;
            p.alu_op              = ALU_OP_ARITH;
            p.rs1                 = inst[9:5];
            p.rs2                 = inst[20:16];
            p.rd                  = inst[4:0];
        end else if (inst[31:22] == OP_ADDI || inst[31:22] == OP_SUBI) begin
            // Source and destination registers are carried so execute can use them.
            p.ctrl[CTRL_ALUSRC]   = 1'b1;
            p.ctrl[CTRL_REGWRITE] = 1'b1;
            p.alu_op              = ALU_OP_ARITH;
            p.rs1                 = inst[9:5];
            p.rd                  = inst[4:0];
            p.imm                 = {52'b0, inst[21:10]};
        end else if (inst[31:23] == OP_MOVK) begin
            p.ctrl[CTRL_MEMTOREG] = 1'b1;
            p.ctrl[CTRL_REGWRITE] = 1'b1;
            p.rs1                 = inst[4:0];
            p.rd                  = inst[4:0];
            p.imm                 = hw << {inst[22:21], 4'b0000};
        end else begin
            p.ctrl[CTRL_ILLEGAL] = 1'b1;
        end
        return p;
    endfunction

endpackage

// File: rtl/dec_inst_fifo.sv
// Instruction/PC queue for the decode stage: DEPTH entries, occupancy count,
// synchronous flush. Full/empty are derived from the count, pointers wrap naturally.
module dec_inst_fifo #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            wr_en,
    input  logic [31:0]     wr_inst,
    input  logic [XLEN-1:0] wr_pc,
    input  logic            rd_en,
    output logic [31:0]     rd_inst,
    output logic [XLEN-1:0] rd_pc,
    output logic [LW-1:0]   level,
    output logic            full
);

    logic [31:0]     inst_mem [DEPTH];
    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic            push;
    logic            pop;

    // A full queue refuses a push even when the head pops on the same edge.
    assign full    = (level == LW'(DEPTH));
    assign push    = wr_en && !full && !flush;
    assign pop     = rd_en && (level != '0) && !flush;
    assign rd_inst = inst_mem[rptr];
    assign rd_pc   = pc_mem[rptr];

    // NOTE: storage is deliberately not reset; only pointers and count carry meaning.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wptr] <= wr_inst;
            pc_mem[wptr]   <= wr_pc;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all updates see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/decode_stage_q.sv
// Queued LEGv8 decode stage: FIFO of fetched words, decode of the head, registered packet out.
// Optional: DEC_ILLEGAL_TRAP_EN stalls the stream after an illegal packet is accepted, until flush.
module decode_stage_q
    import leg_dec_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4,
    localparam int LW   = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] imm,
    output logic [8:0]      ctrl,
    output logic [1:0]      alu_op,
    output logic [LW-1:0]   level
);

    logic            full;
    logic [31:0]     head_inst;
    logic [XLEN-1:0] head_pc;
    dec_pkt_t        head_dec;
    logic            stall;
    logic            load;

    dec_inst_fifo #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .wr_en   (in_valid),
        .wr_inst (in_inst),
        .wr_pc   (in_pc),
        .rd_en   (load),
        .rd_inst (head_inst),
        .rd_pc   (head_pc),
        .level   (level),
        .full    (full)
    );

    assign in_ready = !full;
    assign head_dec = decode(head_inst);

`ifdef DEC_ILLEGAL_TRAP_EN
    logic trapped;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trapped <= 1'b0;
        end else if (flush) begin
            trapped <= 1'b0;
        end else if (out_valid && out_ready && ctrl[CTRL_ILLEGAL]) begin
            trapped <= 1'b1;
        end
    end

    // Also blocks the load on the very edge the illegal packet is taken.
    assign stall = trapped || (out_valid && ctrl[CTRL_ILLEGAL]);
`else
    assign stall = 1'b0;
`endif

    assign load = (level != '0) && (!out_valid || out_ready) && !stall && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_pc    <= '0;
            rs1       <= '0;
            rs2       <= '0;
            rd        <= '0;
            imm       <= '0;
            ctrl      <= '0;
            alu_op    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_pc    <= head_pc;
            rs1       <= head_dec.rs1;
            rs2       <= head_dec.rs2;
            rd        <= head_dec.rd;
            imm       <= head_dec.imm[XLEN-1:0];
            ctrl      <= head_dec.ctrl;
            alu_op    <= head_dec.alu_op;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage_q.sv
// Directed self-checking bench for decode_stage_q (DEPTH=4, XLEN=64).
// Expected values are hand-computed from the LEGv8 encodings listed in the vector table.
module tb_decode_stage_q;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [63:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [63:0] imm;
    logic [8:0]  ctrl;
    logic [1:0]  alu_op;
    logic [2:0]  level;

    int checks;
    int errors;

    typedef struct packed {
        logic [31:0] inst;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [63:0] imm;
        logic [8:0]  ctrl;
        logic [1:0]  alu;
    } vec_t;

    vec_t vecs [16];

    localparam logic [31:0] ADD_X3 = 32'h8B020023;

    decode_stage_q #(.XLEN(64), .DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inst   (in_inst),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .imm       (imm),
        .ctrl      (ctrl),
        .alu_op    (alu_op),
        .level     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_pkt(input string tag, input logic [63:0] pc, input vec_t v);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_pc"},    out_pc, pc);
        check({tag, "_rs1"},   64'(rs1), 64'(v.rs1));
        check({tag, "_rs2"},   64'(rs2), 64'(v.rs2));
        check({tag, "_rd"},    64'(rd), 64'(v.rd));
        check({tag, "_imm"},   imm, v.imm);
        check({tag, "_ctrl"},  64'(ctrl), 64'(v.ctrl));
        check({tag, "_alu"},   64'(alu_op), 64'(v.alu));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // inst, rs1, rs2, rd, imm, ctrl, alu_op
        vecs[0]  = {32'hF85F8062, 5'd3,  5'd0,  5'd2,  64'hFFFF_FFFF_FFFF_FFF8, 9'h036, 2'd0}; // LDUR
        vecs[1]  = {32'hF80100C4, 5'd6,  5'd4,  5'd0,  64'h0000_0000_0000_0010, 9'h10C, 2'd0}; // STUR
        vecs[2]  = {32'h8B020023, 5'd1,  5'd2,  5'd3,  64'h0,                   9'h002, 2'd2}; // ADD
        vecs[3]  = {32'hCB090107, 5'd8,  5'd9,  5'd7,  64'h0,                   9'h002, 2'd2}; // SUB
        vecs[4]  = {32'h8A0C016A, 5'd11, 5'd12, 5'd10, 64'h0,                   9'h002, 2'd2}; // AND
        vecs[5]  = {32'hAA0F01CD, 5'd14, 5'd15, 5'd13, 64'h0,                   9'h002, 2'd2}; // ORR
        vecs[6]  = {32'h913FFC41, 5'd2,  5'd0,  5'd1,  64'h0000_0000_0000_0FFF, 9'h006, 2'd2}; // ADDI
        vecs[7]  = {32'hD1001483, 5'd4,  5'd0,  5'd3,  64'h0000_0000_0000_0005, 9'h006, 2'd2}; // SUBI
        vecs[8]  = {32'hB4FFFF85, 5'd0,  5'd5,  5'd0,  64'hFFFF_FFFF_FFFF_FFFC, 9'h140, 2'd1}; // CBZ
        vecs[9]  = {32'hB5000106, 5'd0,  5'd6,  5'd0,  64'h0000_0000_0000_0008, 9'h140, 2'd1}; // CBNZ
        vecs[10] = {32'h14000010, 5'd0,  5'd0,  5'd0,  64'h0000_0000_0000_0010, 9'h080, 2'd0}; // B
        vecs[11] = {32'h17FFFFFF, 5'd0,  5'd0,  5'd0,  64'hFFFF_FFFF_FFFF_FFFF, 9'h080, 2'd0}; // B -1
        vecs[12] = {32'h97FFFFFE, 5'd0,  5'd0,  5'd0,  64'hFFFF_FFFF_FFFF_FFFE, 9'h080, 2'd0}; // BL -2
        vecs[13] = {32'hF2D7DDE1, 5'd1,  5'd0,  5'd1,  64'h0000_BEEF_0000_0000, 9'h012, 2'd0}; // MOVK 0xBEEF,LSL32
        vecs[14] = {32'hF2C17DE1, 5'd1,  5'd0,  5'd1,  64'h0000_0BEF_0000_0000, 9'h012, 2'd0}; // MOVK imm16=0x0BEF
        vecs[15] = {32'h00000000, 5'd0,  5'd0,  5'd0,  64'h0,                   9'h001, 2'd0}; // illegal

        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_inst   = '0;
        in_pc     = '0;
        out_ready = 1'b0;

        // Reset state
        #12;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_level", 64'(level), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_pc", out_pc, 64'd0);
        check("rst_imm", imm, 64'd0);
        check("rst_ctrl", 64'(ctrl), 64'd0);
        check("rst_fields", 64'({rs1, rs2, rd, alu_op}), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // LDUR latency: accepted at one edge, presented after the next
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_inst   = 32'hF85F8062;
        in_pc     = 64'h100;
        tick();
        in_valid = 1'b0;
        check("ldur_e1_valid", 64'(out_valid), 64'd0);
        check("ldur_e1_level", 64'(level), 64'd1);
        tick();
        check_pkt("ldur", 64'h100, vecs[0]);
        check("ldur_e2_level", 64'(level), 64'd0);
        tick();
        check("ldur_drained", 64'(out_valid), 64'd0);

        // Decode table
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_inst  = vecs[i].inst;
            in_pc    = 64'h1000 + 64'(4 * i);
            tick();
            in_valid = 1'b0;
            tick();
            check_pkt($sformatf("vec%0d", i), 64'h1000 + 64'(4 * i), vecs[i]);
            tick();
        end

        // Fill with out_ready low: first word sits in the output register, next four fill the queue
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_inst  = ADD_X3;
            in_pc    = 64'h200 + 64'(4 * i);
            tick();
        end
        check("fill_level", 64'(level), 64'd4);
        check("fill_in_ready", 64'(in_ready), 64'd0);
        check("fill_head_pc", out_pc, 64'h200);
        in_pc = 64'h214;
        tick();
        in_valid = 1'b0;
        check("fill_ignored_level", 64'(level), 64'd4);
        check("fill_hold_pc", out_pc, 64'h200);
        check("fill_hold_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("drain%0d_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("drain%0d_pc", i), out_pc, 64'h200 + 64'(4 * i));
            tick();
        end
        check("drain_end_valid", 64'(out_valid), 64'd0);
        check("drain_end_level", 64'(level), 64'd0);

        // Flush with three queued and a push offered in the same cycle
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_inst  = ADD_X3;
            in_pc    = 64'h300 + 64'(4 * i);
            tick();
        end
        check("preflush_level", 64'(level), 64'd3);
        flush = 1'b1;
        in_pc = 64'h3F0;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_level", 64'(level), 64'd0);
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("postflush%0d_valid", i), 64'(out_valid), 64'd0);
        end
        in_valid = 1'b1;
        in_pc    = 64'h400;
        tick();
        in_valid = 1'b0;
        tick();
        check("postflush_pkt_pc", out_pc, 64'h400);
        check("postflush_pkt_valid", 64'(out_valid), 64'd1);
        tick();

        // Illegal word followed by ADD
        in_valid = 1'b1;
        in_inst  = 32'h00000000;
        in_pc    = 64'h500;
        tick();
        in_inst = ADD_X3;
        in_pc   = 64'h504;
        tick();
        in_valid = 1'b0;
        check_pkt("illegal", 64'h500, vecs[15]);
        tick();
`ifdef DEC_ILLEGAL_TRAP_EN
        check("trap_valid", 64'(out_valid), 64'd0);
        check("trap_level", 64'(level), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("trap_hold%0d_valid", i), 64'(out_valid), 64'd0);
            check($sformatf("trap_hold%0d_level", i), 64'(level), 64'd1);
        end
        check("trap_in_ready", 64'(in_ready), 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("trap_flush_level", 64'(level), 64'd0);
        in_valid = 1'b1;
        in_pc    = 64'h508;
        tick();
        in_valid = 1'b0;
        tick();
        check("trap_release_valid", 64'(out_valid), 64'd1);
        check("trap_release_pc", out_pc, 64'h508);
        tick();
`else
        check_pkt("after_illegal", 64'h504, vecs[2]);
        tick();
        check("after_illegal_drained", 64'(out_valid), 64'd0);
`endif

        // Asynchronous reset mid-stream with three queued
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_inst  = ADD_X3;
            in_pc    = 64'h600 + 64'(4 * i);
            tick();
        end
        in_valid = 1'b0;
        check("prereset_level", 64'(level), 64'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_level", 64'(level), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk) rst_n = 1'b1;
        tick();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_inst   = 32'hF2D7DDE1;
        in_pc     = 64'h700;
        tick();
        in_valid = 1'b0;
        tick();
        check_pkt("postrst_movk", 64'h700, vecs[13]);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
